if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter XLEN, default 32: width of pc and of the sign-extended immediate.
REQ-002 Parameter CNT_WIDTH, default 16: width of the stall counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  clock; all state changes on its rising edge.
REQ-005 rstn  in  1  asynchronous reset, active low.
REQ-006 in_valid  in  1  upstream (fetch) holds a valid instruction.
REQ-007 in_ready  out  1  stage can accept an instruction this cycle.
REQ-008 inst_i  in  32  raw RV32 instruction.
REQ-009 pc_i  in  XLEN  pc of inst_i.
REQ-010 flush_i  in  1  jump/branch redirect; discards all held instructions.
REQ-011 out_valid  out  1  decoded instruction is presented downstream.
REQ-012 out_ready  in  1  downstream accepts this cycle.
REQ-013 opcode_o/rs1_o/rs2_o/rd_o/funct3_o/funct7_o  out  7/5/5/5/3/7  instruction fields.
REQ-014 imm_o  out  XLEN  sign-extended immediate.
REQ-015 pc_o  out  XLEN  pc of the presented instruction.
REQ-016 stall_cnt_o  out  CNT_WIDTH  count of stalled output cycles.

Function
REQ-017 The stage SHALL accept an instruction on any cycle where in_valid and in_ready are both high and flush_i is low.
REQ-018 The stage SHALL transfer an instruction downstream on any cycle where out_valid and out_ready are both high.
REQ-019 An accepted instruction SHALL appear on the outputs, with out_valid high, on the cycle after acceptance (1-cycle latency).
REQ-020 All field, imm_o and pc_o outputs SHALL be forced to zero while out_valid is low, so an invalid slot reads as a bubble.
REQ-021 The decoded fields SHALL be taken from these instruction bits: opcode = [6:0], rd = [11:7], funct3 = [14:12], rs1 = [19:15], rs2 = [24:20], funct7 = [31:25].
REQ-022 imm_o SHALL be selected by opcode as follows:
- I-type (0000011, 0010011, 1100111): inst[31:20].
- S-type (0100011): {inst[31:25], inst[11:7]}.
- B-type (1100011): {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- U-type (0110111, 0010111): {inst[31:12], 12'b0}.
- J-type (1101111): {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- Any other opcode: imm_o = 0.
REQ-023 imm_o SHALL be sign-extended from inst[31] to XLEN bits in every case that REQ-022 does not set to zero.
REQ-024 The instruction-holding state SHALL be exactly two states, EMPTY and FULL.
REQ-025 State transitions:
- EMPTY -> FULL on accept.
- FULL -> EMPTY on transfer without a simultaneous accept.
- FULL -> FULL on transfer with a simultaneous accept, or on stall.
REQ-026 On a cycle where flush_i is high, the block SHALL move to EMPTY next cycle regardless of the handshakes, and the input offered on that cycle SHALL be discarded.
REQ-027 flush_i SHALL take priority over a simultaneous accept and over a simultaneous transfer.
REQ-028 stall_cnt_o SHALL increment by 1 on every cycle where out_valid is high and out_ready is low.
REQ-029 stall_cnt_o SHALL saturate at all-ones and SHALL NOT wrap.
REQ-030 stall_cnt_o SHALL NOT be cleared by flush_i.

Reset
REQ-031 While rstn is low, the block SHALL be EMPTY, all stored fields and pc SHALL be 0, stall_cnt_o SHALL be 0, and out_valid SHALL be 0.
REQ-032 Reset asserted mid-stall SHALL discard any held or skid-held instruction immediately, without waiting for a clock edge.
REQ-033 in_ready after reset SHALL be 1.

Configuration
REQ-034 Macro IF_ID_SKID_EN SHALL select the buffering structure as follows:
- Defined: add a one-entry skid buffer. in_ready is a registered signal equal to NOT(skid occupied). An instruction accepted while FULL and stalled goes into the skid buffer. The skid contents move into the main slot on the next transfer. Order is strictly preserved. Flush clears both entries.
- Undefined: no skid buffer. in_ready = NOT(FULL) OR out_ready, which is combinational.

Verification
REQ-035 Reset, then in_valid=1 with inst=0x00500093 and pc=0x100 -> next cycle out_valid=1, opcode=0x13, rd=1, rs1=0, imm_o=0x00000005, pc_o=0x100.
REQ-036 inst=0xFE000EE3 (B-type, offset -4) -> imm_o=0xFFFFFFFC; inst=0x123450B7 (lui) -> imm_o=0x12345000.
REQ-037 Hold out_ready=0 for 5 cycles while FULL -> outputs stable, stall_cnt_o advances 0->5. Without IF_ID_SKID_EN, in_ready=0 throughout. With IF_ID_SKID_EN, one extra instruction is accepted, in_ready then drops, and both instructions emerge in order.
REQ-038 Assert flush_i while FULL and while in_valid=1 -> next cycle out_valid=0, all fields 0, in_ready=1, and the flushed-cycle instruction never appears downstream.
REQ-039 Drive rstn low asynchronously mid-stall with stall_cnt_o=3 -> out_valid=0 and stall_cnt_o=0 before the next clock edge.
REQ-040 Force 2^CNT_WIDTH+2 stall cycles -> stall_cnt_o holds all-ones.

Source files
------------

// File: rtl/if_id_stage_if.sv
// Handshake and decoded-field bundle between fetch, the IF/ID stage and decode.
// The master side is whoever drives fetch data and accepts decoded output; the stage is the slave.
interface if_id_stage_if #(
    parameter int XLEN = 32
) ();
    // A beat moves on a side when its valid and ready are both high on a rising clk edge;
    // valid never depends combinationally on ready on the same side.
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst_i;
    logic [XLEN-1:0] pc_i;

    logic            out_valid;
    logic            out_ready;
    logic [6:0]      opcode_o;
    logic [4:0]      rs1_o;
    logic [4:0]      rs2_o;
    logic [4:0]      rd_o;
    logic [2:0]      funct3_o;
    logic [6:0]      funct7_o;
    logic [XLEN-1:0] imm_o;
    logic [XLEN-1:0] pc_o;

    modport master (
        output in_valid, inst_i, pc_i, out_ready,
        input  in_ready, out_valid, opcode_o, rs1_o, rs2_o, rd_o,
               funct3_o, funct7_o, imm_o, pc_o
    );

    modport slave (
        input  in_valid, inst_i, pc_i, out_ready,
        output in_ready, out_valid, opcode_o, rs1_o, rs2_o, rd_o,
               funct3_o, funct7_o, imm_o, pc_o
    );
endinterface

// File: rtl/if_id_stage.sv
// RV32 IF/ID pipeline register with field/immediate decode and a saturating stall counter.
// Define IF_ID_SKID_EN to add a one-entry skid buffer behind the main slot (registered in_ready).
module if_id_stage #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush_i,
    if_id_stage_if.slave         bus,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic                 dbg_state_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic out_valid;
    logic in_ready;
    logic accept;
    logic xfer;

    assign out_valid = (state_q == FULL);
    assign accept    = bus.in_valid & in_ready & ~flush_i;
    assign xfer      = out_valid & bus.out_ready;

`ifdef IF_ID_SKID_EN
    logic            skid_valid_q, skid_valid_d;
    logic [31:0]     skid_inst_q, skid_inst_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic            in_ready_q, in_ready_d;

    assign in_ready = in_ready_q;

    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        pc_d         = pc_q;
        skid_valid_d = skid_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
        if (flush_i) begin
            state_d      = EMPTY;
            skid_valid_d = 1'b0;
        end else if (state_q == EMPTY) begin
            if (accept) begin
                state_d = FULL;
                inst_d  = bus.inst_i;
                pc_d    = bus.pc_i;
            end
        end else if (skid_valid_q) begin
            // in_ready is low while the skid is occupied, so only a drain can happen here.
            if (xfer) begin
                inst_d       = skid_inst_q;
                pc_d         = skid_pc_q;
                skid_valid_d = 1'b0;
            end
        end else if (xfer) begin
            if (accept) begin
                inst_d = bus.inst_i;
                pc_d   = bus.pc_i;
            end else begin
                state_d = EMPTY;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_inst_d  = bus.inst_i;
            skid_pc_d    = bus.pc_i;
        end
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            skid_valid_q <= 1'b0;
            skid_inst_q  <= '0;
            skid_pc_q    <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    assign in_ready = (state_q == EMPTY) | bus.out_ready;

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d = FULL;
            inst_d  = bus.inst_i;
            pc_d    = bus.pc_i;
        end else if (xfer) begin
            state_d = EMPTY;
        end
    end
`endif

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !bus.out_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= EMPTY;
            inst_q      <= '0;
            pc_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            inst_q      <= inst_d;
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Immediate is assembled at 32 bits, then sign-extended from bit 31 to XLEN.
    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        unique case (inst_q[6:0])
            7'b0000011, 7'b0010011, 7'b1100111:
                imm32 = {{20{inst_q[31]}}, inst_q[31:20]};
            7'b0100011:
                imm32 = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
            7'b1100011:
                imm32 = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25],
                         inst_q[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm32 = {inst_q[31:12], 12'b0};
            7'b1101111:
                imm32 = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20],
                         inst_q[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    // An empty slot reads as an all-zero bubble.
    always_comb begin
        bus.opcode_o = out_valid ? inst_q[6:0]   : '0;
        bus.rd_o     = out_valid ? inst_q[11:7]  : '0;
        bus.funct3_o = out_valid ? inst_q[14:12] : '0;
        bus.rs1_o    = out_valid ? inst_q[19:15] : '0;
        bus.rs2_o    = out_valid ? inst_q[24:20] : '0;
        bus.funct7_o = out_valid ? inst_q[31:25] : '0;
        bus.imm_o    = out_valid ? XLEN'(imm32)  : '0;
        bus.pc_o     = out_valid ? pc_q          : '0;
    end

    assign bus.out_valid = out_valid;
    assign bus.in_ready  = in_ready;
    assign stall_cnt_o   = stall_cnt_q;
    assign dbg_state_o   = (state_q == FULL);

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: decode vectors, stall/skid ordering, flush, async reset, saturation.
module tb_if_id_stage;
    localparam int XLEN      = 32;
    localparam int CNT_WIDTH = 16;
`ifdef IF_ID_SKID_EN
    localparam logic SKID = 1'b1;
`else
    localparam logic SKID = 1'b0;
`endif

    logic                 clk;
    logic                 rstn;
    logic                 flush_i;
    logic [CNT_WIDTH-1:0] stall_cnt_o;
    logic                 dbg_state_o;
    int                   checks;
    int                   errors;

    if_id_stage_if #(.XLEN(XLEN)) bus ();

    if_id_stage #(.XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush_i     (flush_i),
        .bus         (bus),
        .stall_cnt_o (stall_cnt_o),
        .dbg_state_o (dbg_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [XLEN-1:0] pc);
        bus.in_valid = 1'b1;
        bus.inst_i   = inst;
        bus.pc_i     = pc;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.inst_i   = '0;
        bus.pc_i     = '0;
    endtask

    task automatic push_check(input string tag, input logic [31:0] inst, input logic [XLEN-1:0] pc,
                              input logic [6:0] exp_op, input logic [XLEN-1:0] exp_imm);
        drive(inst, pc);
        step();
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_opcode"}, bus.opcode_o, exp_op);
        chk({tag, "_imm"}, bus.imm_o, exp_imm);
        chk({tag, "_pc"}, bus.pc_o, pc);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rstn         = 1'b0;
        flush_i      = 1'b0;
        bus.out_ready = 1'b1;
        idle();

        // Reset state
        repeat (2) step();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_stall_cnt", stall_cnt_o, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_state", dbg_state_o, 0);
        chk("rst_pc_o", bus.pc_o, 0);
        chk("rst_imm_o", bus.imm_o, 0);
        rstn = 1'b1;
        step();

        // addi x1, x0, 5 with one-cycle latency
        drive(32'h00500093, 32'h100);
        step();
        idle();
        chk("addi_valid", bus.out_valid, 1);
        chk("addi_opcode", bus.opcode_o, 7'h13);
        chk("addi_rd", bus.rd_o, 1);
        chk("addi_rs1", bus.rs1_o, 0);
        chk("addi_funct3", bus.funct3_o, 0);
        chk("addi_imm", bus.imm_o, 32'h00000005);
        chk("addi_pc", bus.pc_o, 32'h100);
        step();
        chk("bubble_valid", bus.out_valid, 0);
        chk("bubble_opcode", bus.opcode_o, 0);
        chk("bubble_rd", bus.rd_o, 0);
        chk("bubble_imm", bus.imm_o, 0);

        // Back-to-back stream covering each immediate format
        push_check("beq", 32'hFE000EE3, 32'h104, 7'h63, 32'hFFFFFFFC);
        push_check("lui", 32'h123450B7, 32'h108, 7'h37, 32'h12345000);
        chk("lui_rd", bus.rd_o, 1);
        chk("lui_funct7", bus.funct7_o, 7'h09);
        push_check("jal", 32'hFF9FF0EF, 32'h10C, 7'h6F, 32'hFFFFFFF8);
        push_check("sw", 32'h00512423, 32'h110, 7'h23, 32'h00000008);
        chk("sw_rs1", bus.rs1_o, 2);
        chk("sw_rs2", bus.rs2_o, 5);
        chk("sw_funct3", bus.funct3_o, 2);
        push_check("unk", 32'hFFFFFFFF, 32'h114, 7'h7F, 32'h0);
        chk("unk_funct7", bus.funct7_o, 7'h7F);
        idle();
        step();
        chk("stream_drain", bus.out_valid, 0);
        chk("stream_cnt", stall_cnt_o, 0);

        // Five-cycle stall with a second instruction offered throughout
        drive(32'h00700113, 32'h200);
        step();
        bus.out_ready = 1'b0;
        drive(32'h00900193, 32'h204);
        #1;
        chk("stall_in_ready_0", bus.in_ready, SKID);
        chk("stall_cnt_0", stall_cnt_o, 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_pc", bus.pc_o, 32'h200);
            chk("stall_rd", bus.rd_o, 2);
            chk("stall_imm", bus.imm_o, 32'h7);
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_cnt", stall_cnt_o, i);
        end
        bus.out_ready = 1'b1;
        step();
        idle();
        chk("order_second_valid", bus.out_valid, 1);
        chk("order_second_pc", bus.pc_o, 32'h204);
        chk("order_second_rd", bus.rd_o, 3);
        step();
        chk("order_drain", bus.out_valid, 0);
        chk("order_cnt", stall_cnt_o, 5);

        // Flush while FULL with a new instruction offered
        bus.out_ready = 1'b0;
        drive(32'h00B00213, 32'h300);
        step();
        chk("pre_flush_pc", bus.pc_o, 32'h300);
        drive(32'h00D00293, 32'h304);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        idle();
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_opcode", bus.opcode_o, 0);
        chk("flush_rd", bus.rd_o, 0);
        chk("flush_imm", bus.imm_o, 0);
        chk("flush_pc", bus.pc_o, 0);
        chk("flush_in_ready", bus.in_ready, 1);
        chk("flush_cnt", stall_cnt_o, 6);
        bus.out_ready = 1'b1;
        step();
        chk("flush_no_ghost_1", bus.out_valid, 0);
        step();
        chk("flush_no_ghost_2", bus.out_valid, 0);

        // Async reset in the middle of a stall
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        bus.out_ready = 1'b0;
        drive(32'h01000313, 32'h400);
        step();
        drive(32'h01100393, 32'h404);
        repeat (3) step();
        idle();
        chk("pre_arst_cnt", stall_cnt_o, 3);
        chk("pre_arst_valid", bus.out_valid, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_cnt", stall_cnt_o, 0);
        chk("arst_state", dbg_state_o, 0);
        chk("arst_pc", bus.pc_o, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        step();
        rstn = 1'b1;
        bus.out_ready = 1'b1;
        step();
        chk("arst_no_skid_leak", bus.out_valid, 0);

        // Counter saturation
        bus.out_ready = 1'b0;
        drive(32'h01400393, 32'h500);
        step();
        idle();
        repeat ((2 ** CNT_WIDTH) + 2) @(posedge clk);
        #1;
        chk("sat_cnt", stall_cnt_o, {CNT_WIDTH{1'b1}});
        chk("sat_valid", bus.out_valid, 1);
        chk("sat_pc", bus.pc_o, 32'h500);
        step();
        chk("sat_hold", stall_cnt_o, {CNT_WIDTH{1'b1}});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
